// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants, state encoding, tap index type and the output scaling
// helper for the 4-tap FIR MAC sequencer.
//
// Build option:
//   FIR_SAT_EN  defined   -> y_q = acc >>> SHIFT, clamped to the signed
//                            DATA_W range
//               undefined -> y_q = acc[SHIFT+DATA_W-1:SHIFT], wraps
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W = 8;                     // sample / tap width
   localparam int COEF_W = 8;                     // coefficient width, Q1.7
   localparam int NTAPS  = 4;                     // tap count
   localparam int ACC_W  = DATA_W + COEF_W + 2;   // accumulator width
   localparam int SHIFT  = 7;                     // Q1.7 -> integer scaling
   localparam int TAP_W  = $clog2(NTAPS);

   typedef logic [TAP_W-1:0] tap_idx_t;

   // Sequencer states (plain constants so legacy code can share them)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MAC  = ST_MAC,
      DONE = ST_DONE
   } state_e;

   // Limits of the signed DATA_W output range, expressed at ACC_W
   localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

   // Scale the full-precision sum down to DATA_W
   function automatic logic [DATA_W-1:0] scale_q(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] w_sh;
      w_sh = acc >>> SHIFT;
`ifdef FIR_SAT_EN
      if (w_sh > Q_MAX) begin
         scale_q = {1'b0, {(DATA_W - 1){1'b1}}};
      end else if (w_sh < Q_MIN) begin
         scale_q = {1'b1, {(DATA_W - 1){1'b0}}};
      end else begin
         scale_q = w_sh[DATA_W-1:0];
      end
`else
      // Low DATA_W bits of the shifted value == acc[SHIFT+DATA_W-1:SHIFT]
      scale_q = w_sh[DATA_W-1:0];
`endif
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer_if
// Bundles the sample handshake, delay-line controls, coefficient write port
// and result handshake of the FIR MAC sequencer.
//   slave  : the sequencer view (drives in_ready, shift_en, tap_sel, results)
//   master : the surrounding I/O wrapper + delay line + tap mux view
// -----------------------------------------------------------------------------
interface fir_mac_sequencer_if;
   import fir_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] sample_out;
   logic              shift_en;
   tap_idx_t          tap_sel;
   logic [DATA_W-1:0] tap_data;
   logic              cfg_we;
   tap_idx_t          cfg_addr;
   logic [COEF_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  y_out;
   logic [DATA_W-1:0] y_q;

   modport slave (
      input  in_valid, in_data, tap_data, cfg_we, cfg_addr, cfg_data, out_ready,
      output in_ready, sample_out, shift_en, tap_sel, cfg_ready, out_valid,
             y_out, y_q
   );

   modport master (
      output in_valid, in_data, tap_data, cfg_we, cfg_addr, cfg_data, out_ready,
      input  in_ready, sample_out, shift_en, tap_sel, cfg_ready, out_valid,
             y_out, y_q
   );

endinterface

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Signed multiply-accumulate with synchronous clear and enable.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_clr      clear the accumulator at the next edge (wins over i_en)
//   i_en       add i_tap*i_coef at the next edge
//   i_tap      signed tap value
//   i_coef     signed coefficient
//   o_sum      accumulator plus the current product; this is the value the
//              accumulator takes when i_en is high, so the caller can capture
//              the final sum on the same edge as the last tap
// -----------------------------------------------------------------------------
module fir_mac
   import fir_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clr,
   input  logic                     i_en,
   input  logic signed [DATA_W-1:0] i_tap,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic signed [ACC_W-1:0]  o_sum
);

   logic signed [DATA_W+COEF_W-1:0] w_prod;
   logic signed [ACC_W-1:0]         w_prod_ext;
   logic signed [ACC_W-1:0]         r_acc;

   assign w_prod     = i_tap * i_coef;
   assign w_prod_ext = {{(ACC_W - DATA_W - COEF_W){w_prod[DATA_W+COEF_W-1]}}, w_prod};
   assign o_sum      = r_acc + w_prod_ext;

   // Accumulator register: clear on a new sample, accumulate one tap per enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= o_sum;
      end
   end

endmodule

// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
// Time-multiplexed controller for a 4-tap FIR. Accepts one sample per
// handshake, strobes the external delay line, walks tap_sel over x[n]..x[n-3]
// through one shared multiplier and presents the sum on a valid/ready port.
// Also holds the programmable coefficient bank.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus (slave)  in_valid/in_ready/in_data   sample handshake
//                sample_out/shift_en         delay-line input and strobe
//                tap_sel/tap_data            external tap mux
//                cfg_we/cfg_addr/cfg_data/cfg_ready   coefficient write port
//                out_valid/out_ready/y_out/y_q        result handshake
//
// Build option: FIR_SAT_EN selects saturating y_q (see fir_pkg::scale_q).
// -----------------------------------------------------------------------------
module fir_mac_sequencer
   import fir_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fir_mac_sequencer_if.slave bus
);

   logic [1:0]               r_state;
   tap_idx_t                 r_tap_sel;
   logic signed [COEF_W-1:0] r_coef [NTAPS];
   logic [ACC_W-1:0]         r_y_out;
   logic [DATA_W-1:0]        r_y_q;
   logic                     r_out_valid;

   logic                     w_idle;
   logic                     w_mac;
   logic                     w_accept;
   logic                     w_last;
   logic                     w_cfg_wr;
   logic signed [ACC_W-1:0]  w_sum;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_mac    = (r_state == ST_MAC);
   assign w_accept = bus.in_valid & w_idle;
   assign w_last   = w_mac & (r_tap_sel == tap_idx_t'(NTAPS - 1));
   // Writes are only honoured in IDLE so the bank is stable for a whole sample
   assign w_cfg_wr = bus.cfg_we & w_idle;

   assign bus.in_ready   = w_idle;
   assign bus.cfg_ready  = w_idle;
   assign bus.shift_en   = w_accept;
   assign bus.sample_out = bus.in_data;
   assign bus.tap_sel    = r_tap_sel;
   assign bus.out_valid  = r_out_valid;
   assign bus.y_out      = r_y_out;
   assign bus.y_q        = r_y_q;

   fir_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_accept),
      .i_en   (w_mac),
      .i_tap  (bus.tap_data),
      .i_coef (r_coef[r_tap_sel]),
      .o_sum  (w_sum)
   );

   // Sequencer state and tap walk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_tap_sel <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state   <= ST_MAC;
                  r_tap_sel <= '0;
               end
            end
            ST_MAC: begin
               if (w_last) begin
                  r_state   <= ST_DONE;
                  r_tap_sel <= '0;
               end else begin
                  r_tap_sel <= r_tap_sel + tap_idx_t'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_tap_sel <= '0;
            end
         endcase
      end
   end

   // Coefficient bank write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_coef[i] <= '0;
         end
      end else if (w_cfg_wr) begin
         r_coef[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // Result registers: captured from the final sum on the last-tap edge and
   // held through DONE until the consumer takes them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_out     <= '0;
         r_y_q       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_last) begin
         r_y_out     <= w_sum;
         r_y_q       <= scale_q(w_sum);
         r_out_valid <= 1'b1;
      end else if (r_out_valid & bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
// Self-checking bench for fir_mac_sequencer. Models the external 4-stage
// delay line and tap mux, drives a table of samples with hand-computed
// results, then runs hand-written sequences for config lockout, output
// backpressure and reset during MAC.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fir_mac_sequencer_if bus ();

   fir_mac_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External delay line model, x[n] in dl[0]
   logic [7:0] dl [4];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) dl[i] <= 8'd0;
      end else if (bus.shift_en) begin
         dl[0] <= bus.sample_out;
         dl[1] <= dl[0];
         dl[2] <= dl[1];
         dl[3] <= dl[2];
      end
   end
   assign bus.tap_data = dl[bus.tap_sel];

   typedef struct {
      logic [7:0]  d;
      logic [17:0] y;
      logic [7:0]  q_sat;
      logic [7:0]  q_trn;
   } vec_t;

   vec_t tv [13];

   function automatic logic [17:0] yexp(input int v);
      return v[17:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
      end
   endtask

   // All drive/sample tasks run at negedge+1
   task automatic prog(input logic [1:0] a, input logic [7:0] d);
      bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
      @(negedge clk); #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic start_sample(input logic [7:0] d, input bit hold);
      int n;
      bus.in_valid = 1'b1; bus.in_data = d; #1;
      n = 0;
      while (!bus.shift_en && n < 40) begin
         @(negedge clk); #1; n++;
      end
      chk("accept", 32'(bus.shift_en), 32'd1);
      if (!hold) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         @(negedge clk); #1;
      end
   endtask

   // Wait for out_valid (bounded), capture, consume
   task automatic finish_sample(output logic [17:0] y, output logic [7:0] q,
                                output int lat, output int extra_sh);
      lat = 0; extra_sh = 0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk); #1; lat++;
         if (bus.shift_en) extra_sh++;
      end
      chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
      y = bus.y_out; q = bus.y_q;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [17:0] y, y0;
      logic [7:0]  q, eq;
      int          lat, xs, cnt;

      checks = 0; errors = 0;
      tv[0]  = '{8'd100,  18'd6400,  8'd50,   8'd50};
      tv[1]  = '{8'd0,    18'd3200,  8'd25,   8'd25};
      tv[2]  = '{8'd0,    18'd1600,  8'd12,   8'd12};
      tv[3]  = '{8'd0,    18'd800,   8'd6,    8'd6};
      tv[4]  = '{8'd0,    18'd0,     8'd0,    8'd0};
      tv[5]  = '{8'd127,  18'd16129, 8'h7E,   8'h7E};
      tv[6]  = '{8'd127,  18'd32258, 8'h7F,   8'hFC};
      tv[7]  = '{8'd127,  18'd48387, 8'h7F,   8'h7A};
      tv[8]  = '{8'd127,  18'd64516, 8'h7F,   8'hF8};
      tv[9]  = '{8'h80,   18'd32131, 8'h7F,   8'hFB};
      tv[10] = '{8'h80,   yexp(-254),   8'hFE, 8'hFE};
      tv[11] = '{8'h80,   yexp(-32639), 8'h80, 8'h01};
      tv[12] = '{8'h80,   yexp(-65024), 8'h80, 8'h04};

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.cfg_we = 1'b0;
      bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y_out",     32'(bus.y_out),     32'd0);
      chk("rst_y_q",       32'(bus.y_q),       32'd0);
      chk("rst_tap_sel",   32'(bus.tap_sel),   32'd0);
      @(negedge clk); rst = 1'b0; #1;

      // Impulse response
      prog(2'd0, 8'd64); prog(2'd1, 8'd32); prog(2'd2, 8'd16); prog(2'd3, 8'd8);
      for (int i = 0; i < 13; i++) begin
         if (i == 5) begin
            for (int a = 0; a < 4; a++) prog(2'(a), 8'd127);
         end
`ifdef FIR_SAT_EN
         eq = tv[i].q_sat;
`else
         eq = tv[i].q_trn;
`endif
         start_sample(tv[i].d, 1'b1);
         finish_sample(y, q, lat, xs);
         chk($sformatf("vec%0d_y_out", i), 32'(y), 32'(tv[i].y));
         chk($sformatf("vec%0d_y_q", i),   32'(q), 32'(eq));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
         chk($sformatf("vec%0d_shift_pulse", i), 32'(xs), 32'd0);
         chk($sformatf("vec%0d_ov_drop", i), 32'(bus.out_valid), 32'd0);
      end

      // Config lockout: write during MAC is ignored
      prog(2'd0, 8'd64); prog(2'd1, 8'd32); prog(2'd2, 8'd16); prog(2'd3, 8'd8);
      start_sample(8'd10, 1'b0);
      bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 8'h7F; #1;
      chk("lock_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      chk("lock_in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk); #1;
      bus.cfg_we = 1'b0;
      finish_sample(y, q, lat, xs);
      chk("lock_y_old_coef", 32'(y), 32'(yexp(-6528)));
      prog(2'd1, 8'h7F);
      start_sample(8'd20, 1'b0);
      finish_sample(y, q, lat, xs);
      chk("lock_y_new_coef", 32'(y), 32'(yexp(-522)));

      // Backpressure in DONE with in_valid held high
      start_sample(8'd0, 1'b1);
      cnt = 0;
      while (!bus.out_valid && cnt < 40) begin
         @(negedge clk); #1; cnt++;
      end
      y0 = bus.y_out;
      chk("bp_y_out", 32'(y0), 32'd1676);
      for (int k = 0; k < 3; k++) begin
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_y_stable",  32'(bus.y_out),     32'(y0));
         chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
         chk("bp_shift_en",  32'(bus.shift_en),  32'd0);
         @(negedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_ov_drop",     32'(bus.out_valid), 32'd0);
      chk("bp_reaccept",    32'(bus.shift_en),  32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk); #1;
      finish_sample(y, q, lat, xs);
      chk("bp_second_y", 32'(y), 32'd400);

      // Reset asserted mid-MAC
      start_sample(8'd5, 1'b0);
      cnt = 0;
      while (bus.tap_sel != 2'd2 && cnt < 10) begin
         @(negedge clk); #1; cnt++;
      end
      chk("mid_tap_sel", 32'(bus.tap_sel), 32'd2);
      rst = 1'b1; #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_y_out",     32'(bus.y_out),     32'd0);
      chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("mid_rst_tap_sel",   32'(bus.tap_sel),   32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0; #1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.out_valid) cnt++;
         @(negedge clk); #1;
      end
      chk("mid_no_stale_valid", 32'(cnt), 32'd0);
      start_sample(8'd50, 1'b0);
      finish_sample(y, q, lat, xs);
      chk("mid_coefs_cleared_y", 32'(y), 32'd0);
      chk("mid_coefs_cleared_q", 32'(q), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed controller for the 4-tap FIR: accepts one sample per handshake and pulses the shift enable of the external 4-stage sample delay line.
- Walks the tap select over x[n]..x[n-3] and accumulates tap*coef through a single shared multiplier.
- Presents the result on a valid/ready output; holds the programmable coefficient bank and its write port.
- Sits between the chip I/O wrapper and the delay line plus tap mux.

Parameters:
DATA_W, 8, sample and tap width (signed two's complement)
COEF_W, 8, coefficient width (signed, Q1.7)
NTAPS, 4, tap count; tap_sel width = clog2(NTAPS)
ACC_W, DATA_W+COEF_W+2, accumulator / y_out width
SHIFT, 7, right-shift applied to acc to form y_q

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  sample offered
in_ready  out  1  sample accepted when in_valid & in_ready
in_data  in  DATA_W  sample
sample_out  out  DATA_W  in_data passthrough to delay-line input
shift_en  out  1  delay-line shift strobe, = in_valid & in_ready
tap_sel  out  2  selects x0..x3 on the external tap mux
tap_data  in  DATA_W  selected tap value (combinational from mux)
cfg_we  in  1  coefficient write strobe
cfg_addr  in  2  coefficient index
cfg_data  in  COEF_W  coefficient value
cfg_ready  out  1  writes honoured only when high
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
y_out  out  ACC_W  full-precision sum
y_q  out  DATA_W  scaled result (acc >>> SHIFT, see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE, acc=0, all coefs=0, tap_sel=0, out_valid=0.
  - in_ready=1 and cfg_ready=1 (combinational from IDLE).
  - y_out=0, y_q=0.
- Reset asserted mid-operation aborts the computation; no out_valid for that sample.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - cfg_we writes coef[cfg_addr] at the edge.
  - On in_valid: shift_en=1 (delay line shifts at the same edge), acc<=0, tap_sel<=0, go to MAC.
  - cfg_we and in_valid in the same cycle: both take effect; the write is used by this sample.
- MAC:
  - One tap per cycle: acc <= acc + tap_data*coef[tap_sel], signed product, sign-extended to ACC_W.
  - tap_sel increments 0..3. After tap 3, go to DONE and register y_out/y_q from the final sum.
  - in_ready=0 and cfg_ready=0; cfg_we is ignored.
- DONE:
  - out_valid=1; y_out and y_q are held stable until out_ready.
  - out_valid & out_ready -> IDLE, out_valid=0 next cycle.
  - in_ready=0 and cfg_we is ignored while in DONE.
- Latency: sample accepted at edge 0, taps consumed in cycles 1-4, out_valid high from cycle 5. Minimum period is 6 cycles per sample.
- Arithmetic: ACC_W=18 cannot overflow for 4 taps of 8x8 (|sum| <= 65536). tap_sel never exceeds NTAPS-1.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: y_q = (acc >>> SHIFT), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: y_q = acc[SHIFT+DATA_W-1:SHIFT], truncated, wraps.
- y_out is identical in both builds.

Decomposition:
- Package fir_pkg: DATA_W, COEF_W, NTAPS, ACC_W, SHIFT constants; state enum (IDLE/MAC/DONE); tap index type.
- Sub-module fir_mac: signed multiply-accumulate with clear and enable, ACC_W output.
- FSM, coefficient bank and output scaling stay in fir_mac_sequencer.

Test Plan:
- Impulse response, using a bench model of the delay line:
  - Stimulus: coefs {64,32,16,8}; samples 100,0,0,0,0.
  - Response: y_out 6400,3200,1600,800,0; y_q 50,25,12,6,0.
  - Each shift_en lasts exactly 1 cycle; out_valid first asserts 5 cycles after acceptance.
- Saturation:
  - Stimulus: coefs all 127; four samples of 127.
  - Response: fourth y_out=64516; y_q=127 with FIR_SAT_EN, 0xF8 (-8) without.
  - Stimulus: samples all -128 -> y_out=-65024; y_q=-128 with FIR_SAT_EN.
- Config lockout:
  - Stimulus: cfg_we to addr 1 with 0x7F during MAC.
  - Response: cfg_ready=0, coef unchanged, result matches the old coefs. The same write in IDLE takes effect for the next sample.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles in DONE, in_valid held high.
  - Response: out_valid stays 1, y_out stable, in_ready=0, no shift_en. Sample accepted the cycle after return to IDLE.
- Reset mid-MAC:
  - Stimulus: rst asserted with tap_sel=2.
  - Response: immediately out_valid=0, y_out=0, coefs=0, in_ready=1. No stale result after release.
